// File: rtl/prv664_ifetch_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : prv664_ifetch_arbiter_if
// Description : Fetch request, MMU issue and cache return bundle for the
//               instruction fetch arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface prv664_ifetch_arbiter_if #(
    parameter int IDWIDTH = 8
);
    logic                 flush_i;
    logic                 req0_valid_i;
    logic [63:0]          req0_addr_i;
    logic [IDWIDTH-2:0]   req0_id_i;
    logic                 req0_ready_o;
    logic                 req1_valid_i;
    logic [63:0]          req1_addr_i;
    logic [IDWIDTH-2:0]   req1_id_i;
    logic                 req1_ready_o;
    logic                 mmu_valid_o;
    logic [63:0]          mmu_addr_o;
    logic [IDWIDTH-1:0]   mmu_id_o;
    logic [4:0]           mmu_opcode_o;
    logic [9:0]           mmu_funct_o;
    logic                 mmu_full_i;
    logic                 ret_valid_i;
    logic [IDWIDTH-1:0]   ret_id_i;
    logic [5:0]           ret_error_i;
    logic [127:0]         ret_rdata_i;
    logic                 ret0_valid_o;
    logic                 ret1_valid_o;
    logic [IDWIDTH-2:0]   ret_id_o;
    logic [5:0]           ret_error_o;
    logic [127:0]         ret_rdata_o;
    logic [7:0]           outst0_o;
    logic [7:0]           outst1_o;
    logic                 proto_err_o;

    // Arbiter side: owns the MMU request port and the per-port returns.
    modport master (
        input  flush_i,
        input  req0_valid_i, req0_addr_i, req0_id_i,
        output req0_ready_o,
        input  req1_valid_i, req1_addr_i, req1_id_i,
        output req1_ready_o,
        output mmu_valid_o, mmu_addr_o, mmu_id_o, mmu_opcode_o, mmu_funct_o,
        input  mmu_full_i,
        input  ret_valid_i, ret_id_i, ret_error_i, ret_rdata_i,
        output ret0_valid_o, ret1_valid_o, ret_id_o, ret_error_o, ret_rdata_o,
        output outst0_o, outst1_o, proto_err_o
    );

    // Environment side: requesters, MMU queue and cache return path.
    modport slave (
        output flush_i,
        output req0_valid_i, req0_addr_i, req0_id_i,
        input  req0_ready_o,
        output req1_valid_i, req1_addr_i, req1_id_i,
        input  req1_ready_o,
        input  mmu_valid_o, mmu_addr_o, mmu_id_o, mmu_opcode_o, mmu_funct_o,
        output mmu_full_i,
        output ret_valid_i, ret_id_i, ret_error_i, ret_rdata_i,
        input  ret0_valid_o, ret1_valid_o, ret_id_o, ret_error_o, ret_rdata_o,
        input  outst0_o, outst1_o, proto_err_o
    );
endinterface
`default_nettype wire

// File: rtl/prv664_ifetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prv664_ifetch_arbiter
// Description : Two-port instruction fetch arbiter in front of the MMU with
//               port-0 priority, port-1 starvation guard and return routing.
// Revision    : 1.0 - initial release
// ============================================================================
module prv664_ifetch_arbiter #(
    parameter int IDWIDTH      = 8,
    parameter int MAX_OUTST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input wire                      clk_i,
    input wire                      arst_i,
    prv664_ifetch_arbiter_if.master bus
);
    localparam logic [7:0] C_MAX_OUTST    = 8'(MAX_OUTST);
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [4:0] C_OPCODE_LOAD  = 5'b00000;
    localparam logic [9:0] C_FUNCT_128    = {7'b0, 3'b100};

    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic [1:0] w_ret;
    logic [1:0] w_underflow;
    logic [7:0] r_cnt     [2];
    logic [7:0] w_cnt_nxt [2];
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;
    logic       r_proto_err;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign w_elig[0] = bus.req0_valid_i & ~bus.flush_i & (r_cnt[0] < C_MAX_OUTST);
    assign w_elig[1] = bus.req1_valid_i & (r_cnt[1] < C_MAX_OUTST);

    // Port 1 wins when port 0 is idle or when it has lost too many times in a row.
    assign w_grant[1] = ~bus.mmu_full_i & w_elig[1] &
                        ((r_starve == C_STARVE_LIMIT) | ~w_elig[0]);
    assign w_grant[0] = ~bus.mmu_full_i & w_elig[0] & ~w_grant[1];

    assign bus.req0_ready_o = w_grant[0];
    assign bus.req1_ready_o = w_grant[1];
    assign bus.mmu_valid_o  = |w_grant;
    assign bus.mmu_addr_o   = w_grant[1] ? bus.req1_addr_i :
                              w_grant[0] ? bus.req0_addr_i : 64'd0;
    assign bus.mmu_id_o     = w_grant[1] ? {1'b1, bus.req1_id_i} :
                              w_grant[0] ? {1'b0, bus.req0_id_i} : '0;
    assign bus.mmu_opcode_o = C_OPCODE_LOAD;
    assign bus.mmu_funct_o  = C_FUNCT_128;

    // ------------------------------------------------------------------------
    // Return routing
    // ------------------------------------------------------------------------
    assign w_ret[0] = bus.ret_valid_i & ~bus.ret_id_i[IDWIDTH-1];
    assign w_ret[1] = bus.ret_valid_i &  bus.ret_id_i[IDWIDTH-1];

    assign bus.ret0_valid_o = w_ret[0];
    assign bus.ret1_valid_o = w_ret[1];
    assign bus.ret_id_o     = bus.ret_id_i[IDWIDTH-2:0];
    assign bus.ret_error_o  = bus.ret_error_i;
    assign bus.ret_rdata_o  = bus.ret_rdata_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_underflow = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_underflow[n] = w_ret[n] & (r_cnt[n] == 8'd0);
            if (w_grant[n] & ~w_ret[n]) begin
                w_cnt_nxt[n] = r_cnt[n] + 8'd1;
            end else if (~w_grant[n] & w_ret[n] & (r_cnt[n] != 8'd0)) begin
                w_cnt_nxt[n] = r_cnt[n] - 8'd1;
            end
        end
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (bus.flush_i | w_grant[1]) begin
            w_starve_nxt = 4'd0;
        end else if (w_elig[1] & w_grant[0] & (r_starve != C_STARVE_LIMIT)) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_cnt[0]    <= 8'd0;
            r_cnt[1]    <= 8'd0;
            r_starve    <= 4'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_cnt[0]    <= w_cnt_nxt[0];
            r_cnt[1]    <= w_cnt_nxt[1];
            r_starve    <= w_starve_nxt;
            r_proto_err <= r_proto_err | (|w_underflow);
        end
    end

    assign bus.outst0_o    = r_cnt[0];
    assign bus.outst1_o    = r_cnt[1];
    assign bus.proto_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_prv664_ifetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prv664_ifetch_arbiter
// Description : Directed self-checking bench for the fetch arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prv664_ifetch_arbiter;
    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk_i = ~clk_i;

    prv664_ifetch_arbiter_if #(.IDWIDTH(8)) bus ();

    prv664_ifetch_arbiter #(
        .IDWIDTH      (8),
        .MAX_OUTST    (8),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus)
    );

    task automatic idle();
        bus.flush_i      = 1'b0;
        bus.req0_valid_i = 1'b0;
        bus.req0_addr_i  = 64'd0;
        bus.req0_id_i    = 7'd0;
        bus.req1_valid_i = 1'b0;
        bus.req1_addr_i  = 64'd0;
        bus.req1_id_i    = 7'd0;
        bus.mmu_full_i   = 1'b0;
        bus.ret_valid_i  = 1'b0;
        bus.ret_id_i     = 8'd0;
        bus.ret_error_i  = 6'd0;
        bus.ret_rdata_i  = 128'd0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        arst_i = 1'b1;
        @(negedge clk_i);
        arst_i = 1'b0;
    endtask

    task automatic set_both(input logic [6:0] id0, input logic [63:0] a0,
                            input logic [6:0] id1, input logic [63:0] a1);
        bus.req0_valid_i = 1'b1; bus.req0_id_i = id0; bus.req0_addr_i = a0;
        bus.req1_valid_i = 1'b1; bus.req1_id_i = id1; bus.req1_addr_i = a1;
    endtask

    task automatic test_reset();
        idle();
        arst_i = 1'b1;
        @(negedge clk_i);
        #1;
        vectors++;
        if ({bus.outst0_o, bus.outst1_o, bus.proto_err_o} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%h/%b expected 00/00/0",
                     bus.outst0_o, bus.outst1_o, bus.proto_err_o);
        end
        vectors++;
        if ({bus.mmu_valid_o, bus.req0_ready_o, bus.req1_ready_o,
             bus.ret0_valid_o, bus.ret1_valid_o} !== 5'd0 ||
            bus.mmu_addr_o !== 64'd0 || bus.mmu_id_o !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_comb: got valid=%b addr=%h id=%h expected 0",
                     bus.mmu_valid_o, bus.mmu_addr_o, bus.mmu_id_o);
        end
        vectors++;
        if (bus.mmu_opcode_o !== 5'h00 || bus.mmu_funct_o !== 10'h004) begin
            miscompares++;
            $display("FAIL consts: got opcode=%h funct=%h expected 00/004",
                     bus.mmu_opcode_o, bus.mmu_funct_o);
        end
        arst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_addr;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_addr         = 64'h8000_0000 + 64'(16 * i);
            bus.req0_valid_i = 1'b1;
            bus.req0_id_i    = 7'(i + 1);
            bus.req0_addr_i  = exp_addr;
            #1;
            vectors++;
            if (bus.mmu_valid_o !== 1'b1 || bus.mmu_id_o !== 8'(i + 1) ||
                bus.mmu_addr_o !== exp_addr || bus.req0_ready_o !== 1'b1 ||
                bus.req1_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got v=%b id=%h addr=%h rdy=%b%b expected 1/%h/%h/10",
                         i, bus.mmu_valid_o, bus.mmu_id_o, bus.mmu_addr_o,
                         bus.req0_ready_o, bus.req1_ready_o, 8'(i + 1), exp_addr);
            end
            @(negedge clk_i);
        end
        idle();
        #1;
        vectors++;
        if (bus.outst0_o !== 8'd3 || bus.outst1_o !== 8'd0 || bus.mmu_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_outst: got %0d/%0d v=%b expected 3/0 v=0",
                     bus.outst0_o, bus.outst1_o, bus.mmu_valid_o);
        end
    endtask

    task automatic test_starvation();
        logic e1;
        do_reset();
        set_both(7'h11, 64'h1000, 7'h22, 64'h2000);
        for (int c = 0; c < 10; c++) begin
            e1 = ((c % 5) == 4);
            #1;
            vectors++;
            if (bus.mmu_id_o !== (e1 ? 8'hA2 : 8'h11) ||
                bus.mmu_addr_o !== (e1 ? 64'h2000 : 64'h1000) ||
                bus.req1_ready_o !== e1 || bus.req0_ready_o !== !e1) begin
                miscompares++;
                $display("FAIL starve[%0d]: got id=%h rdy=%b%b expected id=%h",
                         c, bus.mmu_id_o, bus.req0_ready_o, bus.req1_ready_o,
                         e1 ? 8'hA2 : 8'h11);
            end
            @(negedge clk_i);
        end
        idle();
    endtask

    task automatic test_full();
        logic e1;
        do_reset();
        set_both(7'h11, 64'h1000, 7'h22, 64'h2000);
        repeat (2) @(negedge clk_i);
        bus.mmu_full_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (bus.mmu_valid_o !== 1'b0 || bus.req0_ready_o !== 1'b0 ||
                bus.req1_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL full[%0d]: got v=%b rdy=%b%b expected 0/00",
                         c, bus.mmu_valid_o, bus.req0_ready_o, bus.req1_ready_o);
            end
            @(negedge clk_i);
        end
        bus.mmu_full_i = 1'b0;
        // Starve was 2 going in, so two more port-0 wins precede port 1.
        for (int c = 0; c < 3; c++) begin
            e1 = (c == 2);
            #1;
            vectors++;
            if (bus.mmu_valid_o !== 1'b1 || bus.mmu_id_o[7] !== e1 || bus.req1_ready_o !== e1) begin
                miscompares++;
                $display("FAIL full_release[%0d]: got v=%b id=%h expected src=%b",
                         c, bus.mmu_valid_o, bus.mmu_id_o, e1);
            end
            @(negedge clk_i);
        end
        idle();
    endtask

    task automatic test_cnt_max();
        do_reset();
        bus.req0_valid_i = 1'b1; bus.req0_id_i = 7'h03; bus.req0_addr_i = 64'h3000;
        repeat (8) @(negedge clk_i);
        #1;
        vectors++;
        if (bus.outst0_o !== 8'd8 || bus.mmu_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL max_fill: got outst0=%0d v=%b expected 8 v=0",
                     bus.outst0_o, bus.mmu_valid_o);
        end
        bus.req1_valid_i = 1'b1; bus.req1_id_i = 7'h44; bus.req1_addr_i = 64'h4000;
        bus.ret_valid_i  = 1'b1; bus.ret_id_i  = 8'h03;
        #1;
        vectors++;
        if (bus.mmu_id_o !== 8'hC4 || bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b1 ||
            bus.ret0_valid_o !== 1'b1 || bus.ret1_valid_o !== 1'b0 || bus.ret_id_o !== 7'h03) begin
            miscompares++;
            $display("FAIL max_grant1: got id=%h rdy=%b%b ret=%b%b rid=%h expected C4/01/10/03",
                     bus.mmu_id_o, bus.req0_ready_o, bus.req1_ready_o,
                     bus.ret0_valid_o, bus.ret1_valid_o, bus.ret_id_o);
        end
        @(negedge clk_i);
        bus.ret_valid_i = 1'b0;
        #1;
        vectors++;
        if (bus.outst0_o !== 8'd7 || bus.outst1_o !== 8'd1 ||
            bus.mmu_id_o !== 8'h03 || bus.req0_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL max_reelig: got %0d/%0d id=%h expected 7/1 id=03",
                     bus.outst0_o, bus.outst1_o, bus.mmu_id_o);
        end
        @(negedge clk_i);
        idle();
        #1;
        vectors++;
        if (bus.outst0_o !== 8'd8) begin
            miscompares++;
            $display("FAIL max_refill: got outst0=%0d expected 8", bus.outst0_o);
        end
    endtask

    task automatic test_flush_return();
        logic e1;
        do_reset();
        bus.req1_valid_i = 1'b1; bus.req1_id_i = 7'h05; bus.req1_addr_i = 64'h5000;
        repeat (2) @(negedge clk_i);
        bus.req0_valid_i = 1'b1; bus.req0_id_i = 7'h06; bus.req0_addr_i = 64'h6000;
        repeat (3) @(negedge clk_i);
        bus.flush_i     = 1'b1;
        bus.ret_valid_i = 1'b1;
        bus.ret_id_i    = 8'h85;
        bus.ret_error_i = 6'h2A;
        bus.ret_rdata_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        #1;
        vectors++;
        if (bus.mmu_id_o !== 8'h85 || bus.mmu_addr_o !== 64'h5000 ||
            bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_grant: got id=%h addr=%h rdy=%b%b expected 85/5000/01",
                     bus.mmu_id_o, bus.mmu_addr_o, bus.req0_ready_o, bus.req1_ready_o);
        end
        vectors++;
        if (bus.ret1_valid_o !== 1'b1 || bus.ret0_valid_o !== 1'b0 || bus.ret_id_o !== 7'h05 ||
            bus.ret_error_o !== 6'h2A ||
            bus.ret_rdata_o !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D) begin
            miscompares++;
            $display("FAIL flush_ret: got ret=%b%b rid=%h err=%h data=%h expected 01/05/2A",
                     bus.ret0_valid_o, bus.ret1_valid_o, bus.ret_id_o,
                     bus.ret_error_o, bus.ret_rdata_o);
        end
        @(negedge clk_i);
        bus.flush_i      = 1'b0;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        #1;
        vectors++;
        if (bus.outst1_o !== 8'd2 || bus.outst0_o !== 8'd3) begin
            miscompares++;
            $display("FAIL flush_cnt: got %0d/%0d expected 3/2", bus.outst0_o, bus.outst1_o);
        end
        @(negedge clk_i);
        bus.ret_valid_i = 1'b0;
        #1;
        vectors++;
        if (bus.outst1_o !== 8'd1) begin
            miscompares++;
            $display("FAIL flush_dec: got outst1=%0d expected 1", bus.outst1_o);
        end
        // Starve restarted from zero: four port-0 wins before port 1 again.
        set_both(7'h06, 64'h6000, 7'h05, 64'h5000);
        for (int c = 0; c < 5; c++) begin
            e1 = (c == 4);
            #1;
            vectors++;
            if (bus.mmu_id_o[7] !== e1 || bus.mmu_valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL flush_starve[%0d]: got id=%h expected src=%b",
                         c, bus.mmu_id_o, e1);
            end
            @(negedge clk_i);
        end
        idle();
    endtask

    task automatic test_proto_err();
        do_reset();
        bus.ret_valid_i = 1'b1;
        bus.ret_id_i    = 8'h10;
        #1;
        vectors++;
        if (bus.ret0_valid_o !== 1'b1 || bus.ret1_valid_o !== 1'b0 ||
            bus.ret_id_o !== 7'h10 || bus.proto_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL perr_route: got ret=%b%b rid=%h perr=%b expected 10/10/0",
                     bus.ret0_valid_o, bus.ret1_valid_o, bus.ret_id_o, bus.proto_err_o);
        end
        @(negedge clk_i);
        idle();
        #1;
        vectors++;
        if (bus.proto_err_o !== 1'b1 || bus.outst0_o !== 8'd0) begin
            miscompares++;
            $display("FAIL perr_set: got perr=%b outst0=%0d expected 1/0",
                     bus.proto_err_o, bus.outst0_o);
        end
        repeat (3) @(negedge clk_i);
        #1;
        vectors++;
        if (bus.proto_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL perr_sticky: got %b expected 1", bus.proto_err_o);
        end
        #1;
        arst_i = 1'b1;
        #1;
        vectors++;
        if (bus.proto_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL perr_async_clear: got %b expected 0", bus.proto_err_o);
        end
        @(negedge clk_i);
        arst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_starvation();
        test_full();
        test_cnt_max();
        test_flush_return();
        test_proto_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prv664_ifetch_arbiter.md
# prv664_ifetch_arbiter

Shares the single instruction-side MMU request port between two fetch requesters: port 0 is the instruction front (demand fetch) and port 1 is a secondary instruction requester (prefetcher or debug fetch). It arbitrates request issue with port-0 priority plus a starvation guard for port 1, and prepends a source bit to the request ID. It routes cache return beats back to the issuing port by that bit and tracks the outstanding access count per port. It sits between the fetch requesters and the MMU/cache return path.

## Interface
- IDWIDTH, 8, MMU/cache ID width; requester IDs are IDWIDTH-1 bits, and the MSB of the MMU ID is the source bit.
- MAX_OUTST, 8, maximum outstanding accesses per port (1..255).
- STARVE_LIMIT, 4, consecutive port-1 losses before port 1 is forced to win (1..15).
- clk_i  in  1  clock
- arst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  pipeline flush; blocks port-0 issue this cycle
- reqN_valid_i  in  1  request valid, N=0,1; must not depend combinationally on reqN_ready_o
- reqN_addr_i  in  64  128-bit-aligned fetch address
- reqN_id_i  in  IDWIDTH-1  requester tag
- reqN_ready_o  out  1  request accepted this cycle when valid & ready
- mmu_valid_o  out  1  request to MMU
- mmu_addr_o  out  64  granted address
- mmu_id_o  out  IDWIDTH  {src, reqN_id_i}
- mmu_opcode_o  out  5  constant `OPCODE_LOAD
- mmu_funct_o  out  10  constant {7'b0,3'b100} (128-bit)
- mmu_full_i  in  1  MMU queue full
- ret_valid_i  in  1  cache return valid
- ret_id_i  in  IDWIDTH  return ID
- ret_error_i  in  6  error code
- ret_rdata_i  in  128  return data
- retN_valid_o  out  1  return for port N
- ret_id_o  out  IDWIDTH-1  ret_id_i without the source bit, shared by both ports
- ret_error_o / ret_rdata_o  out  6 / 128  passthrough, shared by both ports
- outst0_o / outst1_o  out  8  outstanding count per port
- proto_err_o  out  1  sticky: a return arrived for a port with zero outstanding

## Operation
- Eligibility:
  - elig0 = req0_valid_i & !flush_i & (cnt0 < MAX_OUTST).
  - elig1 = req1_valid_i & (cnt1 < MAX_OUTST).
- No grant when mmu_full_i=1.
- Selection:
  - If starve == STARVE_LIMIT and elig1, grant port 1.
  - Otherwise grant port 0 if elig0.
  - Otherwise grant port 1 if elig1.
- On a grant:
  - mmu_valid_o = 1.
  - Address is muxed from the winning port.
  - mmu_id_o = {winner, reqN_id_i}.
  - reqWinner_ready_o = 1. The losing ready is 0.
- When there is no grant, mmu_valid_o=0, mmu_addr_o=0, mmu_id_o=0.
- Starvation counter (4 bit):
  - +1 (saturating at STARVE_LIMIT) when elig1 and port 0 is granted.
  - Cleared when port 1 is granted, or when flush_i=1.
  - Otherwise held.
- Outstanding counters:
  - cntN +1 on a port-N grant.
  - cntN -1 on a return with ret_id_i[MSB]==N.
  - Both in the same cycle: unchanged.
  - A return with cntN==0 leaves cntN=0 and sets proto_err_o.
- Return routing:
  - retN_valid_o = ret_valid_i & (ret_id_i[IDWIDTH-1]==N).
  - Data and error are a combinational passthrough.
- Flush:
  - Only blocks port-0 issue in the flush cycle and clears starve.
  - Outstanding returns still route and decrement. Cancellation is the requester's job.
  - Port 1 may still be granted during flush.

## Timing
- Grant, ready, MMU outputs and return routing are combinational in the same cycle. The only state is cnt0, cnt1, starve and proto_err.
- State updates on the rising edge following the event. outstN_o reflects the registered counter, so a grant is visible in the next cycle.
- Reset values:
  - cnt0 = cnt1 = 0; starve = 0; proto_err_o = 0.
  - All combinational outputs are 0 while valid inputs are 0.
- Reset asserted mid-operation clears all state immediately. In-flight returns after reset count as protocol errors if their counter is 0.
- Throughput is one grant per cycle while mmu_full_i=0.

## Test plan
- Port 0 only, 3 back-to-back valids with ids 1,2,3 and addr 0x80000000/10/20 -> mmu_id_o 0x01,0x02,0x03 in consecutive cycles; outst0_o = 3.
- Both ports valid continuously, STARVE_LIMIT=4 -> grant pattern 0,0,0,0,1 repeating; mmu_id_o MSB=1 every 5th cycle.
- mmu_full_i=1 with both valid -> both readies 0, mmu_valid_o 0, starve unchanged; release -> port 0 granted the next cycle.
- cnt0 at MAX_OUTST=8 with req0 and req1 valid -> port 1 granted; a port-0 return in the same cycle -> cnt0 goes to 7 and port 0 is eligible the next cycle.
- flush_i=1 with both valid -> port 1 granted and starve=0; a return with id 0x85 -> ret1_valid_o=1, ret_id_o=0x05, outst1_o decremented.
- Return with id 0x10 while cnt0=0 -> ret0_valid_o=1, cnt0 stays 0, proto_err_o=1 and stays set until arst_i.
